// File: rtl/seq_detector_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_detector_param_if                                            |
// | Brief   : Pattern-load, serial-bit and match-report bundle of the detector |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             load;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic             din_vld;
  logic             din;
  logic             d;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output load, pat, len, ovl, din_vld, din,
    input  d, armed, match_cnt
  );

  modport slave (
    input  load, pat, len, ovl, din_vld, din,
    output d, armed, match_cnt
  );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_detector_param                                               |
// | Brief   : Loadable serial pattern detector, overlap/non-overlap modes.     |
// |           Macro SEQDET_MATCH_COUNT_EN builds the saturating match counter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam logic [0:0]       c_idle    = 1'b0;
  localparam logic [0:0]       c_run     = 1'b1;
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(PAT_W);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             w_armed;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] w_fill_nxt;
  logic             r_d;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_match;

  assign w_len_ok   = (bus.len != '0) && (bus.len <= c_max_len);
  // load wins over din_vld, so a bit arriving with load is never accepted
  assign w_accept   = bus.din_vld && (r_state == c_run) && !bus.load;
  assign w_hist_nxt = {r_hist[PAT_W-2:0], bus.din};
  assign w_fill_nxt = (r_fill == c_max_len) ? r_fill : r_fill + LEN_W'(1);

  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign w_mask[gi] = (LEN_W'(gi) < r_len);
  end

  assign w_match = w_accept && (w_fill_nxt >= r_len) &&
                   (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.load) w_state_nxt = w_len_ok ? c_run : c_idle;
  end

  always_comb begin
    w_armed = (r_state == c_run);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= '0;
      r_len  <= '0;
      r_hist <= '0;
      r_fill <= '0;
      r_d    <= 1'b0;
    end else if (bus.load) begin
      r_pat  <= bus.pat;
      r_len  <= bus.len;
      r_hist <= '0;
      r_fill <= '0;
      r_d    <= 1'b0;
    end else if (w_accept) begin
      r_hist <= w_hist_nxt;
      // non-overlap mode demands a full fresh pattern after each hit
      r_fill <= (w_match && !bus.ovl) ? '0 : w_fill_nxt;
      r_d    <= w_match;
    end else begin
      r_d    <= 1'b0;
    end
  end

  assign bus.d     = r_d;
  assign bus.armed = w_armed;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.load)        r_cnt <= '0;
    else if (w_match && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.match_cnt = r_cnt;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_detector_param                                            |
// | Brief   : Directed scoreboard bench for seq_detector_param                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit c_cnt_en = 1'b1;
`else
  localparam bit c_cnt_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic sb_q[$];

  seq_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    return c_cnt_en ? 32'(v) : 32'd0;
  endfunction

  // one clock: drive, queue the expected d, then compare d just after the edge
  task automatic cyc(input logic ld, input logic vld, input logic b, input logic exp_d);
    logic e;
    bus.load    = ld;
    bus.din_vld = vld;
    bus.din     = b;
    sb_q.push_back(exp_d);
    @(posedge clk);
    #1;
    bus.load    = 1'b0;
    bus.din_vld = 1'b0;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      chk("d", 32'(bus.d), 32'(e));
    end
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    bus.pat = p;
    bus.len = l;
    bus.ovl = o;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] s1_bits;
    logic [6:0] s1_exp;
    logic [8:0] s2_bits;
    logic [8:0] s2_exp;
    rst = 1'b1;
    bus.load = 1'b0; bus.pat = '0; bus.len = '0; bus.ovl = 1'b0;
    bus.din_vld = 1'b0; bus.din = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_cnt", 32'(bus.match_cnt), exp_cnt(0));
    rst = 1'b0;

    // overlapping 10101 in 1010101: hits at bits 5 and 7
    do_load(8'h15, 4'd5, 1'b1);
    chk("load_armed", 32'(bus.armed), 32'd1);
    chk("load_cnt", 32'(bus.match_cnt), exp_cnt(0));
    s1_bits = 7'b1010101;
    s1_exp  = 7'b0000101;
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b0, 1'b1, s1_bits[i], s1_exp[i]);
      if (i == 5) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("ovl_cnt", 32'(bus.match_cnt), exp_cnt(2));

    // non-overlapping: only the first hit counts
    do_load(8'h15, 4'd5, 1'b0);
    chk("novl_cnt0", 32'(bus.match_cnt), exp_cnt(0));
    s2_bits = 9'b101010101;
    s2_exp  = 9'b000010000;
    for (int i = 8; i >= 0; i--) cyc(1'b0, 1'b1, s2_bits[i], s2_exp[i]);
    chk("novl_cnt", 32'(bus.match_cnt), exp_cnt(1));

    // invalid lengths leave the detector disarmed
    do_load(8'h15, 4'd0, 1'b1);
    chk("len0_armed", 32'(bus.armed), 32'd0);
    chk("len0_cnt", 32'(bus.match_cnt), exp_cnt(0));
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("len0_cnt_end", 32'(bus.match_cnt), exp_cnt(0));
    do_load(8'h15, 4'd9, 1'b1);
    chk("len9_armed", 32'(bus.armed), 32'd0);

    // load colliding with a bit drops the bit and restarts the fill
    do_load(8'h15, 4'd5, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("reload_armed", 32'(bus.armed), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("reload_cnt", 32'(bus.match_cnt), exp_cnt(1));

    // single-bit pattern: every 1 hits, counter saturates at 3
    do_load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      chk("sat_cnt", 32'(bus.match_cnt), exp_cnt((i + 1 > 3) ? 3 : i + 1));
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // reset on the completing bit suppresses the pulse
    do_load(8'h15, 4'd5, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rstmid_armed", 32'(bus.armed), 32'd0);
    chk("rstmid_cnt", 32'(bus.match_cnt), exp_cnt(0));
    cyc(1'b0, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits (2..32).
REQ-002 Parameter LEN_W, default 4, width of len port; SHALL satisfy 2^LEN_W > PAT_W.
REQ-003 Parameter CNT_W, default 8, width of match counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load  input  1  when high, captures pat and len and restarts detection.
REQ-007 pat  input  PAT_W  target pattern; pat[len-1] is the first bit expected, pat[0] the last.
REQ-008 len  input  LEN_W  active pattern length, 1..PAT_W.
REQ-009 ovl  input  1  overlap mode: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-010 din_vld  input  1  serial bit strobe.
REQ-011 din  input  1  serial data bit, sampled when din_vld=1.
REQ-012 d  output  1  one-cycle match pulse.
REQ-013 armed  output  1  high when a valid pattern is loaded and detection is active.
REQ-014 match_cnt  output  CNT_W  number of matches since reset or last load.

Function
REQ-015 Two states: IDLE (no valid pattern) and RUN; reset enters IDLE.
REQ-016 IDLE->RUN on load=1 with 1<=len<=PAT_W; load with len=0 or len>PAT_W enters or stays in IDLE.
REQ-017 load in RUN: recapture pat/len and clear history, fill count and match_cnt; this takes priority over any din_vld in the same cycle, and that bit is discarded.
REQ-018 Internal history register hist[PAT_W-1:0]: on din_vld in RUN, hist <= {hist[PAT_W-2:0], din}; din_vld in IDLE is ignored.
REQ-019 Fill counter fill saturates at PAT_W, increments per accepted bit, and is cleared on load.
REQ-020 Match condition, evaluated on the updated history: the new fill >= len and the low len bits of hist equal pat[len-1:0].
REQ-021 d SHALL be registered and asserted exactly one cycle after the clock edge accepting the completing bit (latency 1); d is otherwise 0.
REQ-022 ovl=1: history and fill are kept after a match, so a trailing prefix can start the next match.
REQ-023 ovl=0: fill clears on a match, so the next match needs len fresh bits.
REQ-024 ovl is sampled on every accepted bit; changing it mid-stream takes effect on the next accepted bit.
REQ-025 match_cnt increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
REQ-026 armed = (state == RUN).

Reset
REQ-027 rst SHALL dominate load and din_vld.
REQ-028 Reset values: d=0, armed=0, match_cnt=0, hist=0, fill=0, stored pat=0, stored len=0, state=IDLE.
REQ-029 rst mid-sequence discards partial progress, and no d pulse is produced for the bit presented in the reset cycle.

Configuration
REQ-030 Macro SEQDET_MATCH_COUNT_EN: when defined, match_cnt behaves as in REQ-014/REQ-025.
REQ-031 When SEQDET_MATCH_COUNT_EN is undefined, match_cnt is constant 0, no counter flops are built, and all other behaviour is identical.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- rst=1 two cycles, then load pat=8'h15 len=5 ovl=1; bits 1,0,1,0,1,0,1 -> d pulses after bit 5 and after bit 7; match_cnt=2.
- Same load with ovl=0; bits 1,0,1,0,1,0,1,0,1 -> d pulses after bits 5 and 10 only if bits 6-10 are 10101; with the given stream, d pulses once and match_cnt=1.
- load len=0 -> armed stays 0; 10 bits of din=1 -> d never asserts.
- In RUN after 4 matching bits of 10101, assert load (same pat) together with din_vld -> that bit is dropped, fill=0, and 5 further bits 10101 are needed for d.
- PAT_W=8, CNT_W=2, pat=8'h01 len=1, ovl=1, six bits of 1 -> six d pulses and match_cnt saturates at 3 (with the macro) or stays 0 (without it).
- rst asserted on the cycle of the 5th bit of 10101 -> d=0 and armed=0 next cycle.
